fft_twiddle_sequencer: RTL and testbench
========================================

// Module: fft_twiddle_sequencer
// PURPOSE
//   Sequences twiddle-coefficient lookups for the radix-2 DIT FFT engine (default N=128).
//   After a start pulse it walks every stage s = 0..LOG2N-1 and every butterfly b = 0..N/2-1.
//   For each (s, b) it issues one twiddle ROM address plus stage/butterfly tags.
//   It sits between the top-level FFT control and the coefficient ROM / butterfly datapath.
//   The datapath enable (en) stalls the sequencer without losing position.
// PARAMETERS
//   N      128  FFT length; power of two, N >= 4
//   LOG2N  7    log2(N); must match N
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   start      in   1        request a full FFT pass; sampled only in IDLE
//   en         in   1        datapath enable; 0 stalls the sequence (no counter advance, tw_valid=0)
//   tw_addr    out  LOG2N-1  twiddle ROM index k, range 0..N/2-1
//   tw_valid   out  1        tw_addr/stage/bfly valid this cycle
//   stage      out  [$clog2(LOG2N)-1:0]  stage tag s of current tw_addr
//   bfly       out  LOG2N-1  butterfly tag b of current tw_addr
//   stage_last out  1        qualifies tw_valid: b == N/2-1 (last butterfly of the stage)
//   busy       out  1        high in RUN and DONE
//   done       out  1        one-cycle pulse after the final address of the pass
// BEHAVIOUR
//   - Reset: state=IDLE; internal s=0, b=0; all outputs 0 (tw_addr, tw_valid, stage, bfly,
//     stage_last, busy, done). Reset has priority over all inputs and aborts a pass
//     mid-run; there is no done pulse for an aborted pass.
//   - Outputs and counters are registered; no combinational path from input to output.
//   - FSM, evaluated at posedge:
//     IDLE: if start -> RUN, s<=0, b<=0. Else stay. tw_valid<=0, done<=0.
//     RUN & en:
//       - tw_valid<=1, stage<=s, bfly<=b.
//       - tw_addr <= (b & ((1<<s)-1)) << (LOG2N-1-s); truncate to LOG2N-1 bits.
//       - stage_last<=(b==N/2-1).
//       - Advance: b<=b+1; on b==N/2-1, b<=0 and s<=s+1.
//       - On s==LOG2N-1 and b==N/2-1 -> DONE.
//     RUN & !en: tw_valid<=0, stage_last<=0; tw_addr/stage/bfly and counters hold.
//     DONE: done<=1 for exactly one cycle; tw_valid<=0 -> IDLE. en is ignored in DONE.
//   - Latency: start sampled at edge E0; first tw_valid is high after E1 if en=1 at E1.
//   - Throughput: one address per cycle while en=1. A full pass is LOG2N*N/2 valid cycles
//     (448 for N=128); tw_valid is never asserted in DONE.
//   - done is high in the cycle immediately after the final tw_valid. busy falls in the same
//     cycle done is high.
//   - start while busy (RUN/DONE) is ignored; it is not queued. start in the cycle done is
//     high is sampled in IDLE and accepted.
//   - en toggling never skips or repeats a (s, b) pair.
// TESTING
//   1 Reset: hold rst 3 cycles, start=1 -> all outputs 0, busy=0.
//     Release rst with start=0 -> stays IDLE.
//   2 Full pass, N=8/LOG2N=3, en=1:
//     - start pulse -> 12 valid cycles with tw_addr = 0,0,0,0 | 0,2,0,2 | 0,1,2,3.
//     - stage = 0x4,1x4,2x4; stage_last on the 4th, 8th and 12th.
//     - done one cycle after the last valid.
//   3 Stall, N=8: drive en=0 for 3 cycles after the 5th valid -> tw_valid=0 and tw_addr holds 0.
//     The 6th valid resumes with tw_addr=2, stage=1, bfly=1. Total valids remain 12.
//   4 start while busy: pulse start at valid #3 and at the done cycle.
//     - First pulse ignored.
//     - Second pulse starts a new pass; its first valid arrives 2 cycles later.
//   5 Reset mid-run: N=128, assert rst at valid #200 -> next cycle IDLE with outputs 0, no done.
//     A new start gives a clean pass of 448 valids.
//   6 Default N=128:
//     - Count 448 valids.
//     - Stage 6 tw_addr equals bfly (0..63).
//     - Stage 0 all 0.
//     - Stage 3 tw_addr = (b&7)<<3.

Source files
------------

// File: rtl/fft_twiddle_sequencer.sv
// Twiddle-address sequencer for a radix-2 DIT FFT: walks every (stage, butterfly)
// pair once per start and emits one ROM index per enabled cycle, plus stage/butterfly tags.
module fft_twiddle_sequencer #(
  parameter int N     = 128,
  parameter int LOG2N = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       en,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       tw_valid,
  output logic [$clog2(LOG2N)-1:0]   stage,
  output logic [LOG2N-2:0]           bfly,
  output logic                       stage_last,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  localparam int BW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [BW-1:0]   b_q;
  logic [BW-1:0]   tw_addr_q;
  logic            tw_valid_q;
  logic [SW-1:0]   stage_q;
  logic [BW-1:0]   bfly_q;
  logic            stage_last_q;
  logic            busy_q;
  logic            done_q;

  logic [BW-1:0]   mask_d;
  logic [SW-1:0]   shamt_d;
  logic [BW-1:0]   tw_addr_d;
  logic            b_last;
  logic            s_last;

  // Twiddle index for the current (s, b): the low s bits of b, shifted up to
  // the top of the LOG2N-1 bit index space.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < BW; i++) begin
      if (i < int'(s_q)) mask_d[i] = 1'b1;
    end
    shamt_d   = SW'(LOG2N - 1) - s_q;
    tw_addr_d = (b_q & mask_d) << shamt_d;
  end

  assign b_last = (b_q == BW'(N / 2 - 1));
  assign s_last = (s_q == SW'(LOG2N - 1));

  // tw_valid marks a new (tw_addr, stage, bfly) each cycle it is high; there is no
  // back-pressure beyond en, which freezes position and drops tw_valid for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_q          <= '0;
      b_q          <= '0;
      tw_addr_q    <= '0;
      tw_valid_q   <= 1'b0;
      stage_q      <= '0;
      bfly_q       <= '0;
      stage_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tw_valid_q   <= 1'b0;
          stage_last_q <= 1'b0;
          done_q       <= 1'b0;
          if (start) begin
            state_q <= RUN;
            s_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          done_q <= 1'b0;
          if (en) begin
            tw_valid_q   <= 1'b1;
            stage_q      <= s_q;
            bfly_q       <= b_q;
            tw_addr_q    <= tw_addr_d;
            stage_last_q <= b_last;
            if (b_last) begin
              b_q <= '0;
              if (s_last) state_q <= DONE;
              else        s_q     <= s_q + 1'b1;
            end else begin
              b_q <= b_q + 1'b1;
            end
          end else begin
            tw_valid_q   <= 1'b0;
            stage_last_q <= 1'b0;
          end
        end
        DONE: begin
          tw_valid_q   <= 1'b0;
          stage_last_q <= 1'b0;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          tw_valid_q   <= 1'b0;
          stage_last_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign tw_addr    = tw_addr_q;
  assign tw_valid   = tw_valid_q;
  assign stage      = stage_q;
  assign bfly       = bfly_q;
  assign stage_last = stage_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Bench for fft_twiddle_sequencer: an N=8 instance and a default N=128 instance,
// each with an expected-result queue filled at start and drained by a negedge monitor.
module tb_fft_twiddle_sequencer;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s, en_s, start_l, en_l;

  logic [1:0] addr_s, stage_s, bfly_s, st_s;
  logic       valid_s, last_s, busy_s, done_s;
  logic [5:0] addr_l, bfly_l;
  logic [2:0] stage_l;
  logic [1:0] st_l;
  logic       valid_l, last_l, busy_l, done_l;

  fft_twiddle_sequencer #(.N(8), .LOG2N(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .en(en_s),
    .tw_addr(addr_s), .tw_valid(valid_s), .stage(stage_s), .bfly(bfly_s),
    .stage_last(last_s), .busy(busy_s), .done(done_s), .dbg_state(st_s)
  );

  fft_twiddle_sequencer dut_l (
    .clk(clk), .rst(rst), .start(start_l), .en(en_l),
    .tw_addr(addr_l), .tw_valid(valid_l), .stage(stage_l), .bfly(bfly_l),
    .stage_last(last_l), .busy(busy_l), .done(done_l), .dbg_state(st_l)
  );

  // scoreboard state: entry = {final, last, stage[2:0], bfly[5:0], addr[5:0]}
  logic [16:0] exp_q_s[$];
  logic [16:0] exp_q_l[$];
  logic [16:0] e_s, e_l;
  int n_checks = 0;
  int n_pass   = 0;
  int cnt_s = 0, cnt_l = 0, done_cnt_s = 0, done_cnt_l = 0;
  bit exp_done_s = 1'b0, exp_done_l = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [16:0] mk(input bit fin, input bit last, input int s,
                                     input int b, input int a);
    return {fin, last, 3'(s), 6'(b), 6'(a)};
  endfunction

  task automatic push_small();
    int tab[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    for (int i = 0; i < 12; i++)
      exp_q_s.push_back(mk(i == 11, (i % 4) == 3, i / 4, i % 4, tab[i]));
  endtask

  task automatic push_large();
    int a;
    for (int s = 0; s < 7; s++) begin
      for (int b = 0; b < 64; b++) begin
        if (s == 0)      a = 0;
        else if (s == 6) a = b;
        else             a = (b % (1 << s)) * (1 << (6 - s));
        exp_q_l.push_back(mk(s == 6 && b == 63, b == 63, s, b, a));
      end
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (exp_done_s || done_s) begin
      check_eq("done_s_pulse", {31'b0, done_s}, {31'b0, exp_done_s});
      if (exp_done_s) check_eq("busy_s_at_done", {31'b0, busy_s}, 0);
    end
    if (done_s) done_cnt_s++;
    exp_done_s = 1'b0;
    if (valid_s) begin
      cnt_s++;
      if (exp_q_s.size() == 0) begin
        check_eq("valid_s_without_expect", {31'b0, valid_s}, 0);
      end else begin
        e_s = exp_q_s.pop_front();
        check_eq("addr_s",  {30'b0, addr_s},  {26'b0, e_s[5:0]});
        check_eq("bfly_s",  {30'b0, bfly_s},  {26'b0, e_s[11:6]});
        check_eq("stage_s", {30'b0, stage_s}, {29'b0, e_s[14:12]});
        check_eq("last_s",  {31'b0, last_s},  {31'b0, e_s[15]});
        exp_done_s = e_s[16];
      end
    end
  end

  always @(negedge clk) begin
    if (exp_done_l || done_l) begin
      check_eq("done_l_pulse", {31'b0, done_l}, {31'b0, exp_done_l});
      if (exp_done_l) check_eq("busy_l_at_done", {31'b0, busy_l}, 0);
    end
    if (done_l) done_cnt_l++;
    exp_done_l = 1'b0;
    if (valid_l) begin
      cnt_l++;
      if (exp_q_l.size() == 0) begin
        check_eq("valid_l_without_expect", {31'b0, valid_l}, 0);
      end else begin
        e_l = exp_q_l.pop_front();
        check_eq("addr_l",  {26'b0, addr_l},  {26'b0, e_l[5:0]});
        check_eq("bfly_l",  {26'b0, bfly_l},  {26'b0, e_l[11:6]});
        check_eq("stage_l", {29'b0, stage_l}, {29'b0, e_l[14:12]});
        check_eq("last_l",  {31'b0, last_l},  {31'b0, e_l[15]});
        exp_done_l = e_l[16];
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit big);
    if (big) start_l = 1'b1; else start_s = 1'b1;
    step();
    start_l = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_valids(input bit big, input int target, input int budget, input string tag);
    int i = 0;
    while (((big ? cnt_l : cnt_s) < target) && i < budget) begin
      step();
      i++;
    end
    if ((big ? cnt_l : cnt_s) < target) check_eq(tag, big ? cnt_l : cnt_s, target);
  endtask

  task automatic wait_done(input bit big, input int budget, input string tag);
    int i = 0;
    while (!(big ? done_l : done_s) && i < budget) begin
      step();
      i++;
    end
    check_eq(tag, {31'b0, big ? done_l : done_s}, 1);
  endtask

  task automatic check_zero_l(input string tag);
    check_eq({tag, "_valid"}, {31'b0, valid_l}, 0);
    check_eq({tag, "_addr"},  {26'b0, addr_l}, 0);
    check_eq({tag, "_stage"}, {29'b0, stage_l}, 0);
    check_eq({tag, "_bfly"},  {26'b0, bfly_l}, 0);
    check_eq({tag, "_last"},  {31'b0, last_l}, 0);
    check_eq({tag, "_busy"},  {31'b0, busy_l}, 0);
    check_eq({tag, "_done"},  {31'b0, done_l}, 0);
    check_eq({tag, "_state"}, {30'b0, st_l}, 0);
  endtask

  int lat;
  int done_before;

  initial begin
    rst = 1'b1; start_s = 1'b1; start_l = 1'b1; en_s = 1'b1; en_l = 1'b1;
    repeat (3) step();

    // reset with start held
    check_eq("rst_s_valid", {31'b0, valid_s}, 0);
    check_eq("rst_s_addr",  {30'b0, addr_s}, 0);
    check_eq("rst_s_stage", {30'b0, stage_s}, 0);
    check_eq("rst_s_bfly",  {30'b0, bfly_s}, 0);
    check_eq("rst_s_last",  {31'b0, last_s}, 0);
    check_eq("rst_s_busy",  {31'b0, busy_s}, 0);
    check_eq("rst_s_done",  {31'b0, done_s}, 0);
    check_zero_l("rst_l");
    rst = 1'b0; start_s = 1'b0; start_l = 1'b0;
    repeat (3) step();
    check_eq("idle_s_busy",  {31'b0, busy_s}, 0);
    check_eq("idle_s_state", {30'b0, st_s}, 0);
    check_eq("idle_l_busy",  {31'b0, busy_l}, 0);

    // full N=8 pass
    cnt_s = 0;
    push_small();
    pulse_start(1'b0);
    wait_done(1'b0, 40, "pass_s_done");
    check_eq("pass_s_count", cnt_s, 12);
    repeat (2) step();

    // stall after the 5th valid
    cnt_s = 0;
    push_small();
    pulse_start(1'b0);
    wait_valids(1'b0, 5, 40, "stall_reach5");
    en_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_valid", {31'b0, valid_s}, 0);
      check_eq("stall_addr_hold", {30'b0, addr_s}, 0);
    end
    en_s = 1'b1;
    step();
    check_eq("resume_addr",  {30'b0, addr_s}, 2);
    check_eq("resume_stage", {30'b0, stage_s}, 1);
    check_eq("resume_bfly",  {30'b0, bfly_s}, 1);
    wait_done(1'b0, 40, "stall_done");
    check_eq("stall_count", cnt_s, 12);
    repeat (2) step();

    // start while busy is ignored; start during done is accepted
    cnt_s = 0;
    push_small();
    pulse_start(1'b0);
    wait_valids(1'b0, 3, 40, "busy_reach3");
    pulse_start(1'b0);
    wait_done(1'b0, 40, "busy_done");
    check_eq("busy_count", cnt_s, 12);
    cnt_s = 0;
    push_small();
    start_s = 1'b1;
    lat = 0;
    do begin
      step();
      start_s = 1'b0;
      lat++;
    end while (!valid_s && lat < 10);
    check_eq("restart_latency", lat, 2);
    wait_done(1'b0, 40, "restart_done");
    check_eq("restart_count", cnt_s, 12);
    check_eq("done_s_total", done_cnt_s, 4);
    check_eq("q_s_empty", exp_q_s.size(), 0);

    // N=128 abort by reset after valid #200
    cnt_l = 0;
    push_large();
    pulse_start(1'b1);
    wait_valids(1'b1, 200, 400, "abort_reach200");
    done_before = done_cnt_l;
    rst = 1'b1;
    exp_q_l.delete();
    exp_done_l = 1'b0;
    step();
    check_zero_l("abort_l");
    rst = 1'b0;
    repeat (4) step();
    check_eq("abort_no_done", done_cnt_l, done_before);
    check_eq("abort_idle_busy", {31'b0, busy_l}, 0);

    // clean N=128 pass
    cnt_l = 0;
    push_large();
    pulse_start(1'b1);
    wait_done(1'b1, 600, "pass_l_done");
    check_eq("pass_l_count", cnt_l, 448);
    check_eq("q_l_empty", exp_q_l.size(), 0);
    check_eq("done_l_total", done_cnt_l, done_before + 1);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
